// File: rtl/ising_ctrl_pkg.sv
// Shared types, timing constants and arithmetic helpers for the Ising run sequencer.
package ising_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, PREP, ACTIVE, READOUT} state_t;

   localparam int unsigned MIN_INTERVAL  = 8;
   localparam int unsigned PREP_CYCLES   = 3;
   localparam int unsigned SETTLE_CYCLES = 4;

   // Unsigned add clipped at lim; the wide sum cannot wrap for 32-bit operands.
   function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                           input int unsigned lim);
      longint unsigned sum;
      sum = longint'(a) + longint'(b);
      return (sum > longint'(lim)) ? lim : int'(sum[31:0]);
   endfunction

endpackage

// File: rtl/ising_cu_prog_sweep.sv
// Coupling-unit programming sweep: one enable cycle then one gap cycle per row, top row first.
module ising_cu_prog_sweep
   import ising_ctrl_pkg::*;
#(
   parameter int unsigned N_CU_ROWS = 50,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 clear,
   input  logic                 launch,
   output logic [N_CU_ROWS-1:0] cu_prog_ena,
   output logic                 load_done
);

   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_CU_ROWS - 1);

   logic             active_q;
   logic             gap_q;
   logic [CNT_W-1:0] row_q;
   logic             done_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         active_q <= 1'b0;
         gap_q    <= 1'b0;
         row_q    <= '0;
         done_q   <= 1'b0;
      end else if (clear) begin
         active_q <= 1'b0;
         gap_q    <= 1'b0;
         row_q    <= '0;
         done_q   <= 1'b0;
      end else if (launch && !active_q) begin
         active_q <= 1'b1;
         gap_q    <= 1'b0;
         row_q    <= '0;
      end else if (active_q) begin
         gap_q <= ~gap_q;
         if (gap_q) begin
            if (row_q == LAST_ROW) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end else begin
               row_q <= row_q + 1'b1;
            end
         end
      end
   end

   assign cu_prog_ena = (active_q && !gap_q)
                      ? ({{(N_CU_ROWS-1){1'b0}}, 1'b1} << (LAST_ROW - row_q))
                      : '0;
   assign load_done   = done_q;

endmodule

// File: rtl/ising_run_sequencer.sv
// Run/rerun sequencer for the Ising array: IC programming, enables, Langevin walk and read-out.
// Optional anneal schedule shift register is built only when ISING_ANNEAL_SCH_EN is defined.
module ising_run_sequencer
   import ising_ctrl_pkg::*;
#(
   parameter int unsigned N_CU_ROWS  = 50,
   parameter int unsigned LANGEVIN_W = 16,
   parameter int unsigned SCH_LEN    = 128,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_abort,
   input  logic                  i_load,
   input  logic                  i_run,
   input  logic                  i_rerun,
   input  logic [CNT_W-1:0]      i_total_run,
   input  logic [CNT_W-1:0]      i_total_rerun,
   input  logic [CNT_W-1:0]      i_run_interval,
   input  logic [CNT_W-1:0]      i_rerun_step,
   input  logic [1:0]            i_fix_langevin_sel,
   input  logic [SCH_LEN-1:0]    i_anneal_sch,
   input  logic                  i_anneal_tick,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [CNT_W-1:0]      o_run_cnt,
   output logic [CNT_W-1:0]      o_rerun_cnt,
   output logic                  o_pre_prog_ic,
   output logic                  o_prog_ic,
   output logic [N_CU_ROWS-1:0]  o_cu_prog_ena,
   output logic                  o_load_done,
   output logic                  o_ccii_ena,
   output logic                  o_fix_ena,
   output logic                  o_langevin_ena,
   output logic [LANGEVIN_W-1:0] o_langevin_bank,
   output logic                  o_anneal_bit,
   output logic                  o_readout_ena,
   output logic                  o_readout_valid,
   output logic                  o_final_run
);

   localparam int unsigned      CNT_MAX   = (1 << CNT_W) - 1;
   localparam logic [CNT_W-1:0] MIN_IV    = CNT_W'(MIN_INTERVAL);
   localparam logic [CNT_W-1:0] PREP_LAST = CNT_W'(PREP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PREP_CNT  = CNT_W'(PREP_CYCLES);
   localparam logic [CNT_W-1:0] FIX_TAIL  = CNT_W'(SETTLE_CYCLES + 1);

   state_t           state_q, state_d;
   logic             req_q, abort_q, is_run_q, done_q;
   logic [CNT_W-1:0] cyc_q, iv_q, base_q, run_cnt_q, rerun_cnt_q;

   logic             start_edge, abort_edge, start_is_run, quota_ok, accept;
   logic [CNT_W-1:0] run_iv, rerun_sum, rerun_iv, new_iv, act_last;
   logic [CNT_W:0]   done_sum, quota_sum;

   assign start_edge   = (i_run | i_rerun) & ~req_q;
   assign abort_edge   = i_abort & ~abort_q;
   assign start_is_run = i_run;
   assign quota_ok     = start_is_run ? (run_cnt_q != i_total_run) : (rerun_cnt_q != i_total_rerun);
   assign accept       = (state_q == IDLE) && start_edge && quota_ok;

   assign run_iv    = (i_run_interval < MIN_IV) ? MIN_IV : i_run_interval;
   assign rerun_sum = CNT_W'(sat_add(32'(base_q), 32'(i_rerun_step), CNT_MAX));
   assign rerun_iv  = (rerun_sum < MIN_IV) ? MIN_IV : rerun_sum;
   assign new_iv    = start_is_run ? run_iv : rerun_iv;
   assign act_last  = iv_q - CNT_W'(2);

   always_comb begin
      // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = PREP;
         PREP:    if (cyc_q == PREP_LAST) state_d = ACTIVE;
         ACTIVE:  if (cyc_q == act_last) state_d = READOUT;
         READOUT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_edge) state_d = IDLE;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         abort_q     <= 1'b0;
         is_run_q    <= 1'b0;
         done_q      <= 1'b0;
         cyc_q       <= '0;
         iv_q        <= '0;
         base_q      <= '0;
         run_cnt_q   <= '0;
         rerun_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= i_run | i_rerun;
         abort_q <= i_abort;
         if (abort_edge) begin
            is_run_q    <= 1'b0;
            done_q      <= 1'b0;
            cyc_q       <= '0;
            iv_q        <= '0;
            base_q      <= '0;
            run_cnt_q   <= '0;
            rerun_cnt_q <= '0;
         end else begin
            done_q <= (state_q == READOUT);
            cyc_q  <= (state_q == IDLE) ? '0 : cyc_q + 1'b1;
            if (accept) begin
               iv_q     <= new_iv;
               base_q   <= new_iv;
               is_run_q <= start_is_run;
            end
            if (state_q == READOUT) begin
               if (is_run_q) run_cnt_q   <= run_cnt_q + 1'b1;
               else          rerun_cnt_q <= rerun_cnt_q + 1'b1;
            end
         end
      end
   end

   assign o_busy          = (state_q != IDLE);
   assign o_done          = done_q;
   assign o_run_cnt       = run_cnt_q;
   assign o_rerun_cnt     = rerun_cnt_q;
   assign o_ccii_ena      = o_busy;
   assign o_pre_prog_ic   = (state_q == PREP) && is_run_q && (cyc_q == '0);
   assign o_prog_ic       = (state_q == PREP) && is_run_q && (cyc_q == PREP_LAST);
   assign o_fix_ena       = i_fix_langevin_sel[1] && (state_q == ACTIVE) && (cyc_q <= iv_q - FIX_TAIL);
   assign o_langevin_ena  = i_fix_langevin_sel[0] && ((state_q == ACTIVE) || (state_q == READOUT))
                            && (32'(cyc_q) < PREP_CYCLES + LANGEVIN_W);
   assign o_langevin_bank = o_langevin_ena ? (LANGEVIN_W'(1) << (cyc_q - PREP_CNT)) : '0;
   assign o_readout_ena   = (state_q == ACTIVE) && (cyc_q == act_last);
   assign o_readout_valid = (state_q == READOUT);

   // Quota comparison carries one extra bit so run+rerun totals cannot wrap.
   assign done_sum    = {1'b0, run_cnt_q} + {1'b0, rerun_cnt_q};
   assign quota_sum   = {1'b0, i_total_run} + {1'b0, i_total_rerun};
   assign o_final_run = (done_sum == quota_sum) && (quota_sum != '0);

   ising_cu_prog_sweep #(
      .N_CU_ROWS (N_CU_ROWS),
      .CNT_W     (CNT_W)
   ) u_sweep (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .clear       (abort_edge),
      .launch      (o_prog_ic & i_load & ~o_load_done),
      .cu_prog_ena (o_cu_prog_ena),
      .load_done   (o_load_done)
   );

`ifdef ISING_ANNEAL_SCH_EN
   logic [SCH_LEN-1:0] sch_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)         sch_q <= '0;
      else if (!o_fix_ena) sch_q <= i_anneal_sch;
      else if (i_anneal_tick) sch_q <= sch_q >> 1;
   end

   assign o_anneal_bit = o_fix_ena & sch_q[0];
`else
   logic sch_unused;
   assign sch_unused   = ^{i_anneal_sch, i_anneal_tick};
   assign o_anneal_bit = 1'b0;
`endif

endmodule

// File: tb/tb_ising_run_sequencer.sv
// Directed bench for ising_run_sequencer: vector table of run/rerun starts plus sweep, abort and quota sequences.
module tb_ising_run_sequencer;

   logic         i_clk = 1'b0;
   logic         i_rstn, i_abort, i_load, i_run, i_rerun, i_anneal_tick;
   logic [7:0]   i_total_run, i_total_rerun, i_run_interval, i_rerun_step;
   logic [1:0]   i_fix_langevin_sel;
   logic [127:0] i_anneal_sch;
   logic         o_busy, o_done, o_pre_prog_ic, o_prog_ic, o_load_done, o_ccii_ena, o_fix_ena;
   logic         o_langevin_ena, o_anneal_bit, o_readout_ena, o_readout_valid, o_final_run;
   logic [7:0]   o_run_cnt, o_rerun_cnt;
   logic [49:0]  o_cu_prog_ena;
   logic [15:0]  o_langevin_bank;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_run  = 0;
   int exp_rerun = 0;

   ising_run_sequencer dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_abort(i_abort), .i_load(i_load),
      .i_run(i_run), .i_rerun(i_rerun), .i_total_run(i_total_run), .i_total_rerun(i_total_rerun),
      .i_run_interval(i_run_interval), .i_rerun_step(i_rerun_step),
      .i_fix_langevin_sel(i_fix_langevin_sel), .i_anneal_sch(i_anneal_sch), .i_anneal_tick(i_anneal_tick),
      .o_busy(o_busy), .o_done(o_done), .o_run_cnt(o_run_cnt), .o_rerun_cnt(o_rerun_cnt),
      .o_pre_prog_ic(o_pre_prog_ic), .o_prog_ic(o_prog_ic), .o_cu_prog_ena(o_cu_prog_ena),
      .o_load_done(o_load_done), .o_ccii_ena(o_ccii_ena), .o_fix_ena(o_fix_ena),
      .o_langevin_ena(o_langevin_ena), .o_langevin_bank(o_langevin_bank), .o_anneal_bit(o_anneal_bit),
      .o_readout_ena(o_readout_ena), .o_readout_valid(o_readout_valid), .o_final_run(o_final_run)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic       r;
      logic       rr;
      logic [7:0] iv;
      logic [7:0] step;
      logic [1:0] sel;
      int         exp_i;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ctrl_now();
      return 64'({o_busy, o_done, o_pre_prog_ic, o_prog_ic, o_ccii_ena, o_fix_ena, o_langevin_ena,
                  o_readout_ena, o_readout_valid, o_anneal_bit, o_langevin_bank});
   endfunction

   function automatic logic [63:0] ctrl_exp(input logic b, d, pp, p, c, f, l, re, rv, a,
                                            input logic [15:0] bank);
      return 64'({b, d, pp, p, c, f, l, re, rv, a, bank});
   endfunction

   function automatic logic final_exp();
      int tot;
      tot = int'(i_total_run) + int'(i_total_rerun);
      return (exp_run + exp_rerun == tot) && (tot != 0);
   endfunction

   task automatic start_req(input logic r, input logic rr, output logic got);
      got = 1'b0;
      i_run = r;
      i_rerun = rr;
      for (int w = 0; w < 4 && !got; w++) begin
         tick();
         got = o_busy;
      end
      i_run = 1'b0;
      i_rerun = 1'b0;
      check("start_accepted", 64'(got), 64'(1));
   endtask

   // Walks one accepted run/rerun from T0 to T0+I against the cycle-by-cycle timing expectations.
   task automatic run_trace(input logic r, input logic rr, input logic [7:0] iv, input logic [7:0] step,
                            input logic [1:0] sel, input int exp_i);
      logic got, ef, el, ea;
      logic [15:0] eb;
      i_run_interval = iv;
      i_rerun_step = step;
      i_fix_langevin_sel = sel;
      start_req(r, rr, got);
      if (got) begin
         for (int k = 0; k < exp_i; k++) begin
            ef = sel[1] && k >= 3 && k <= exp_i - 5;
            el = sel[0] && k >= 3 && k <= 18 && k <= exp_i - 1;
            eb = el ? (16'h1 << (k - 3)) : 16'h0;
`ifdef ISING_ANNEAL_SCH_EN
            ea = ef && ((k - 3) % 2 == 0);
`else
            ea = 1'b0;
`endif
            check($sformatf("cycle%0d_of_I%0d", k, exp_i), ctrl_now(),
                  ctrl_exp(1'b1, 1'b0, r && k == 0, r && k == 2, 1'b1, ef, el,
                           k == exp_i - 2, k == exp_i - 1, ea, eb));
            tick();
         end
         if (r) exp_run++;
         else   exp_rerun++;
         check($sformatf("done_I%0d", exp_i), ctrl_now(),
               ctrl_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0));
         check("counters", 64'({o_final_run, o_run_cnt, o_rerun_cnt}),
               64'({final_exp(), 8'(exp_run), 8'(exp_rerun)}));
      end
   endtask

   task automatic refused_start(input logic r, input logic rr, input string name);
      logic seen;
      seen = 1'b0;
      i_run = r;
      i_rerun = rr;
      for (int w = 0; w < 10; w++) begin
         tick();
         if (o_busy | o_pre_prog_ic | o_prog_ic | o_ccii_ena | o_done) seen = 1'b1;
         if (w == 0) begin
            i_run = 1'b0;
            i_rerun = 1'b0;
         end
      end
      check(name, 64'(seen), 64'(0));
      check({name, "_counters"}, 64'({o_run_cnt, o_rerun_cnt}), 64'({8'(exp_run), 8'(exp_rerun)}));
   endtask

   initial begin
      logic got;
      logic [49:0] ecu;

      vecs[0] = '{1'b1, 1'b0, 8'd20, 8'd3,   2'b11, 20};
      vecs[1] = '{1'b0, 1'b1, 8'd20, 8'd3,   2'b11, 23};
      vecs[2] = '{1'b0, 1'b1, 8'd20, 8'd3,   2'b10, 26};
      vecs[3] = '{1'b1, 1'b1, 8'd5,  8'd3,   2'b11, 8};
      vecs[4] = '{1'b0, 1'b1, 8'd5,  8'd3,   2'b01, 11};
      vecs[5] = '{1'b1, 1'b0, 8'd0,  8'd0,   2'b00, 8};
      vecs[6] = '{1'b0, 1'b1, 8'd0,  8'd250, 2'b11, 255};

      i_rstn = 1'b0; i_abort = 1'b0; i_load = 1'b0; i_run = 1'b0; i_rerun = 1'b0;
      i_total_run = 8'd10; i_total_rerun = 8'd10; i_run_interval = 8'd20; i_rerun_step = 8'd3;
      i_fix_langevin_sel = 2'b11; i_anneal_sch = {64{2'b01}}; i_anneal_tick = 1'b1;

      tick();
      tick();
      check("reset_ctrl", ctrl_now(), 64'h0);
      check("reset_state", 64'({o_load_done, o_final_run, o_run_cnt, o_rerun_cnt, o_cu_prog_ena}), 64'h0);
      i_rstn = 1'b1;
      tick();
      check("post_reset_ctrl", ctrl_now(), 64'h0);

      foreach (vecs[i])
         run_trace(vecs[i].r, vecs[i].rr, vecs[i].iv, vecs[i].step, vecs[i].sel, vecs[i].exp_i);

      // Coefficient sweep launched by the IC programming strobe of a run.
      i_load = 1'b1;
      i_run_interval = 8'd20;
      start_req(1'b1, 1'b0, got);
      if (got) begin
         for (int k = 0; k < 105; k++) begin
            ecu = '0;
            if (k >= 3 && k <= 102 && (k - 3) % 2 == 0) ecu[49 - (k - 3) / 2] = 1'b1;
            check($sformatf("sweep_k%0d", k), 64'({o_load_done, o_cu_prog_ena}), 64'({k >= 103, ecu}));
            tick();
         end
         exp_run++;
      end
      i_load = 1'b0;

      // Abort in the middle of a run clears everything on the following cycle.
      i_fix_langevin_sel = 2'b11;
      start_req(1'b1, 1'b0, got);
      for (int k = 0; k < 10; k++) tick();
      i_abort = 1'b1;
      tick();
      exp_run = 0;
      exp_rerun = 0;
      check("abort_ctrl", ctrl_now(), 64'h0);
      check("abort_state", 64'({o_load_done, o_final_run, o_run_cnt, o_rerun_cnt}), 64'h0);
      check("abort_cu", 64'(o_cu_prog_ena), 64'h0);
      tick();
      i_abort = 1'b0;
      tick();

      // Quota handling: two runs plus one rerun reach the final run, further starts are refused.
      i_total_run = 8'd2;
      i_total_rerun = 8'd1;
      run_trace(1'b1, 1'b0, 8'd8, 8'd0, 2'b11, 8);
      run_trace(1'b1, 1'b0, 8'd8, 8'd0, 2'b11, 8);
      check("final_run_before_last", 64'(o_final_run), 64'(0));
      run_trace(1'b0, 1'b1, 8'd8, 8'd0, 2'b11, 8);
      check("final_run_reached", 64'(o_final_run), 64'(1));
      refused_start(1'b1, 1'b0, "refused_run");
      refused_start(1'b0, 1'b1, "refused_rerun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
